// File: rtl/char_anim_pkg.sv
// Shared sprite codes and facing constants for the character animation path.
// Sprite codes must stay identical to the display controller's sprite table.
package char_anim_pkg;

    localparam logic [2:0] SPR_IDLE_1    = 3'd0;
    localparam logic [2:0] SPR_IDLE_2    = 3'd1;
    localparam logic [2:0] SPR_CHARGE    = 3'd2;
    localparam logic [2:0] SPR_JUMP_UP   = 3'd3;
    localparam logic [2:0] SPR_JUMP_DOWN = 3'd4;
    localparam logic [2:0] SPR_FALL      = 3'd5;

    localparam logic signed [1:0] FACE_RIGHT = 2'sb01;
    localparam logic signed [1:0] FACE_LEFT  = 2'sb11;

    typedef enum logic [2:0] {
        ST_IDLE_1    = SPR_IDLE_1,
        ST_IDLE_2    = SPR_IDLE_2,
        ST_CHARGE    = SPR_CHARGE,
        ST_JUMP_UP   = SPR_JUMP_UP,
        ST_JUMP_DOWN = SPR_JUMP_DOWN,
        ST_FALL      = SPR_FALL
    } anim_state_e;

    // Only the two real directions update facing; 00 and 10 mean "keep".
    function automatic logic face_valid(input logic signed [1:0] f);
        return (f == FACE_RIGHT) || (f == FACE_LEFT);
    endfunction

endpackage

// File: rtl/anim_frame_timer.sv
// Loadable up/down frame counter; every update is gated by the frame tick.
// Flags report zero and a caller-supplied terminal value.
module anim_frame_timer #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 inc,
    input  logic                 dec,
    input  logic [CNT_WIDTH-1:0] term_val,
    output logic                 at_zero,
    output logic                 at_term
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            if (load)
                cnt_d = load_val;
            else if (inc)
                cnt_d = cnt_q + 1'b1;
            else if (dec)
                cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign at_zero = (cnt_q == '0);
    assign at_term = (cnt_q == term_val);

endmodule

// File: rtl/char_anim_sequencer.sv
// Frame-synchronous character animation sequencer: sprite code and facing update only on frame_tick.
// Optional CHAR_ANIM_DEBOUNCE_EN requires two agreeing ticks before a mid-air up/down flip.
module char_anim_sequencer
    import char_anim_pkg::*;
#(
    parameter int IDLE_FRAMES = 30,
    parameter int LAND_FRAMES = 8,
    parameter int CNT_WIDTH   = 6
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              frame_tick,
    input  logic              on_ground,
    input  logic              charging,
    input  logic              rising,
    input  logic signed [1:0] face_req,
    output logic [2:0]        char_id,
    output logic signed [1:0] char_face,
    output logic              anim_busy
);

    localparam logic [CNT_WIDTH-1:0] IDLE_TERM = CNT_WIDTH'(IDLE_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] LAND_TERM = CNT_WIDTH'(LAND_FRAMES - 1);

    anim_state_e          state_q, state_d;
    logic signed [1:0]    face_q, face_d;
    logic                 ld, inc, dec;
    logic [CNT_WIDTH-1:0] ld_val;
    logic                 at_zero, at_term;
    logic                 airborne;
`ifdef CHAR_ANIM_DEBOUNCE_EN
    logic                 pend_q, pend_d;
`endif

    assign airborne = (state_q == ST_JUMP_UP) || (state_q == ST_JUMP_DOWN);

    always_comb begin
        state_d = state_q;
        face_d  = face_q;
        ld      = 1'b0;
        ld_val  = '0;
        inc     = 1'b0;
        dec     = 1'b0;
`ifdef CHAR_ANIM_DEBOUNCE_EN
        pend_d  = pend_q;
`endif
        if (frame_tick) begin
`ifdef CHAR_ANIM_DEBOUNCE_EN
            pend_d = 1'b0;
`endif
            if (!on_ground) begin
                ld = 1'b1;
                if (!airborne) begin
                    state_d = rising ? ST_JUMP_UP : ST_JUMP_DOWN;
                end else begin
`ifdef CHAR_ANIM_DEBOUNCE_EN
                    // A disagreeing rising must be seen on two ticks in a row.
                    if (rising != (state_q == ST_JUMP_UP)) begin
                        if (pend_q)
                            state_d = rising ? ST_JUMP_UP : ST_JUMP_DOWN;
                        else
                            pend_d = 1'b1;
                    end
`else
                    state_d = rising ? ST_JUMP_UP : ST_JUMP_DOWN;
`endif
                end
            end else if (airborne) begin
                state_d = ST_FALL;
                ld      = 1'b1;
                ld_val  = LAND_TERM;
            end else begin
                case (state_q)
                    ST_FALL: begin
                        if (at_zero) begin
                            state_d = charging ? ST_CHARGE : ST_IDLE_1;
                            ld      = 1'b1;
                        end else begin
                            dec = 1'b1;
                        end
                    end
                    ST_CHARGE: begin
                        if (!charging) begin
                            state_d = ST_IDLE_1;
                            ld      = 1'b1;
                        end
                    end
                    default: begin
                        if (charging) begin
                            state_d = ST_CHARGE;
                        end else if (at_term) begin
                            state_d = (state_q == ST_IDLE_1) ? ST_IDLE_2 : ST_IDLE_1;
                            ld      = 1'b1;
                        end else begin
                            inc = 1'b1;
                        end
                    end
                endcase
            end

            // Facing is frozen in the air and during the landing hold.
            if ((state_d == ST_IDLE_1 || state_d == ST_IDLE_2 || state_d == ST_CHARGE)
                && face_valid(face_req))
                face_d = face_req;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE_1;
            face_q  <= FACE_RIGHT;
        end else begin
            state_q <= state_d;
            face_q  <= face_d;
        end
    end

`ifdef CHAR_ANIM_DEBOUNCE_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            pend_q <= 1'b0;
        else
            pend_q <= pend_d;
    end
`endif

    anim_frame_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .tick     (frame_tick),
        .load     (ld),
        .load_val (ld_val),
        .inc      (inc),
        .dec      (dec),
        .term_val (IDLE_TERM),
        .at_zero  (at_zero),
        .at_term  (at_term)
    );

    assign char_id   = state_q;
    assign char_face = face_q;
    assign anim_busy = (state_q == ST_FALL);

endmodule

// File: doc/char_anim_sequencer.md
# char_anim_sequencer

Frame-synchronous animation sequencer that drives the character display controller. It turns the character's physical state (ground contact, charge input, vertical direction, facing request) into `char_id` and `char_face`. Both outputs change only on frame boundaries, so the sprite never switches mid-frame. It sits between the physics/game-logic block and the character display controller; its `char_id` codes are the display controller's sprite codes 0..5.

## Interface
- `IDLE_FRAMES`, default 30: frame ticks per idle pose before toggling IDLE_1/IDLE_2; legal range 1..63.
- `LAND_FRAMES`, default 8: frame ticks the FALL_TO_GROUND pose is held after landing; legal range 1..63.
- `CNT_WIDTH`, default 6: width of the internal frame counter.
- `sys_clk` in, 1: system clock.
- `sys_rst_n` in, 1: reset, asynchronous, active-low.
- `frame_tick` in, 1: single-cycle pulse, once per frame at vertical blank.
- `on_ground` in, 1: character is standing on a platform.
- `charging` in, 1: jump button held.
- `rising` in, 1: vertical velocity upward; meaningful only when `!on_ground`.
- `face_req` in, signed 2: requested facing; 01 = right, 11 = left, 00 = no change.
- `char_id` out, 3: sprite code; 0 IDLE_1, 1 IDLE_2, 2 CHARGE, 3 JUMP_UP, 4 JUMP_DOWN, 5 FALL_TO_GROUND.
- `char_face` out, signed 2: current facing, 01 or 11 only.
- `anim_busy` out, 1: high while in FALL_TO_GROUND (landing hold).

## Operation
- States match the `char_id` codes. `char_id` is the registered state.
- All transitions are evaluated only on a cycle with `frame_tick` = 1. Inputs are ignored on other cycles.
- Transition priority, highest first:
  - `!on_ground`: go to JUMP_UP if `rising`, else JUMP_DOWN. This applies from any state, including during the landing hold.
  - `on_ground` in JUMP_UP/JUMP_DOWN: go to FALL_TO_GROUND; counter ← LAND_FRAMES−1.
  - FALL_TO_GROUND: if counter = 0, go to CHARGE if `charging`, else IDLE_1 with counter ← 0. Otherwise counter decrements. `charging` does not shorten the hold.
  - IDLE_1/IDLE_2 with `charging`: go to CHARGE.
  - CHARGE with `!charging`: go to IDLE_1, counter ← 0.
  - IDLE_x: when counter = IDLE_FRAMES−1, toggle to the other idle pose and set counter ← 0. Otherwise counter increments.
- Facing:
  - At `frame_tick`, a nonzero `face_req` is latched into `char_face` only when the next state is IDLE_1, IDLE_2 or CHARGE.
  - Facing is frozen while airborne or landing.
  - 10 on `face_req` is treated as 00.
- The counter never wraps: its values are bounded by the parameters, and out-of-range parameters are illegal.

## Timing
- Reset values: `char_id` = 0 (IDLE_1), `char_face` = 01, `anim_busy` = 0, counter = 0, debounce state cleared.
- Latency: inputs are sampled on the `frame_tick` cycle. New `char_id`/`char_face` are visible one cycle later and are held constant until the next `frame_tick`.
- Consecutive `frame_tick` pulses on back-to-back cycles are each processed.
- Asynchronous reset mid-animation returns all outputs to reset values immediately, with no partial landing hold.
- Simultaneous `!on_ground` and `charging`: the airborne transition wins.

## Configuration
- `CHAR_ANIM_DEBOUNCE_EN` defined:
  - While airborne, a JUMP_UP↔JUMP_DOWN switch occurs only after `rising` has held the new value for 2 consecutive `frame_tick`s.
  - The initial airborne entry, chosen from the current `rising`, is immediate.
- Undefined: `rising` is used directly on every tick.

## Structure
- Shared package `char_anim_pkg`:
  - The six state/sprite codes (3-bit localparams 0..5), identical to the display controller's sprite codes.
  - Facing constants FACE_RIGHT = 01 and FACE_LEFT = 11.
- One sub-module, `anim_frame_timer`: a loadable up/down frame counter, with increment/decrement/load gated by `frame_tick`, and terminal-count flags.

## Test plan
- Reset, then 30 ticks with `on_ground`=1, `charging`=0 → `char_id` goes 0→1 one cycle after tick 30, and back to 0 after tick 60.
- `charging`=1 at a tick while in IDLE_2 → `char_id`=2 next cycle. Release at a later tick → `char_id`=0.
- `on_ground`=0, `rising`=1 for 3 ticks, then `rising`=0 → 3,3,3 then 4 (with the macro: one extra tick of 3). Then `on_ground`=1 → 5 with `anim_busy`=1 for exactly 8 ticks, then 0.
- `face_req`=11 while airborne → `char_face` stays 01. After landing completes and the sequencer is back in IDLE, `face_req`=11 at a tick → `char_face`=11.
- `on_ground` drops during tick 4 of the landing hold → `char_id`=3 or 4 immediately; the hold is abandoned.
- Assert `sys_rst_n`=0 mid-CHARGE between ticks → `char_id`=0 and `char_face`=01 without waiting for a clock edge.
